// File: rtl/lisa_ssa_pkg.sv
// rtl/lisa_ssa_pkg.sv - shared SSA constants and types
//
// Purpose: SSA ID width, SSA ID type and the default register-file sizing.
// The register file and its writeback arbiter both use these.
// Ports: none (package).
package lisa_ssa_pkg;

    localparam int unsigned SSA_ID_W     = 8;
    localparam int unsigned DEF_NUM_REGS = 256;
    localparam int unsigned DEF_DATA_W   = 32;

    typedef logic [SSA_ID_W-1:0] ssa_id_t;

endpackage : lisa_ssa_pkg

// File: rtl/lisa_rr_arbiter.sv
// rtl/lisa_rr_arbiter.sv - round-robin priority search with pointer register
//
// Purpose: grants the first requester at or above the pointer, wrapping modulo
// NUM_REQ. After a grant to i, the pointer moves to i+1. This gives each
// continuously-requesting agent one grant per NUM_REQ grants. Reusable for any
// shared single-issue port.
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset; suppresses all grants
//   req_i       in   [NUM_REQ] request vector
//   grant_o     out  [NUM_REQ] one-hot grant, or zero
//   grant_idx_o out  index of the granted requester (valid with grant_vld_o)
//   grant_vld_o out  a grant is issued this cycle
module lisa_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               grant_vld_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] grant_idx;
    logic             found;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[PTR_W-1:0];
    endfunction

    // Scan from the farthest offset back to the pointer, so the nearest
    // requester at or above the pointer is the last one written and wins.
    always_comb begin
        grant_idx = ptr_q;
        found     = 1'b0;
        idx       = ptr_q;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            idx = wrap_add(ptr_q, k - 1);
            if (req_i[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        grant_o     = '0;
        grant_vld_o = found & ~rst;
        grant_idx_o = grant_idx;
        ptr_d       = ptr_q;
        if (grant_vld_o) begin
            grant_o[grant_idx] = 1'b1;
            ptr_d              = wrap_add(grant_idx, 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : lisa_rr_arbiter

// File: rtl/lisa_ssa_wb_arbiter.sv
// rtl/lisa_ssa_wb_arbiter.sv - round-robin writeback arbiter for the SSA regfile
//
// Purpose: shares the single register-file write port among NUM_REQ producers.
// At most one request is accepted per cycle. The accepted write appears on
// wen/waddr/wdata one cycle later.
// Optional feature macro: LISA_SSA_WRITE_ONCE_CHECK_EN. When defined, a
// written-bitmap enforces write-once SSA semantics. A duplicate write is
// consumed but suppressed, and it raises a sticky error.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid         in   [NUM_REQ] per-requester write request
//   req_ready         out  [NUM_REQ] per-requester accept (one-hot or zero)
//   req_addr          in   [NUM_REQ*8] packed SSA IDs, requester i at [8i+7:8i]
//   req_data          in   [NUM_REQ*DATA_W] packed write data
//   clear             in   start of a new SSA region (clears the bitmap)
//   wen/waddr/wdata   out  register-file write port
//   busy              out  wen or any pending request
//   err_double_write  out  sticky write-once violation flag
//   err_addr          out  SSA ID of the first violation
module lisa_ssa_wb_arbiter
    import lisa_ssa_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*SSA_ID_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic                         clear,
    output logic                         wen,
    output logic [SSA_ID_W-1:0]          waddr,
    output logic [DATA_W-1:0]            wdata,
    output logic                         busy,
    output logic                         err_double_write,
    output logic [SSA_ID_W-1:0]          err_addr
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_vld;
    ssa_id_t            sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               dup;

    logic               wen_q,   wen_d;
    ssa_id_t            waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    lisa_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_valid),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    assign req_ready = grant;
    assign sel_addr  = req_addr[32'(grant_idx)*SSA_ID_W +: SSA_ID_W];
    assign sel_data  = req_data[32'(grant_idx)*DATA_W +: DATA_W];

`ifdef LISA_SSA_WRITE_ONCE_CHECK_EN
    logic [NUM_REGS-1:0] written_q;
    logic                err_q;
    ssa_id_t             err_addr_q;

    // A clear in the same cycle wipes history, so the accompanying write is
    // treated as the first write of the new region.
    assign dup = written_q[sel_addr] & ~clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            written_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (clear) begin
                written_q <= '0;
            end
            if (grant_vld) begin
                written_q[sel_addr] <= 1'b1;
            end
            if (grant_vld && dup) begin
                err_q <= 1'b1;
                if (!err_q) begin
                    err_addr_q <= sel_addr;
                end
            end
        end
    end

    assign err_double_write = err_q;
    assign err_addr         = err_addr_q;
`else
    localparam int unsigned UNUSED_NUM_REGS = NUM_REGS;
    logic unused_clear;

    assign unused_clear     = clear;
    assign dup              = 1'b0;
    assign err_double_write = 1'b0;
    assign err_addr         = '0;
`endif

    // A suppressed duplicate leaves the write port's address/data untouched.
    always_comb begin
        wen_d   = grant_vld & ~dup;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (wen_d) begin
            waddr_d = sel_addr;
            wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = wen_q | (|req_valid);

endmodule : lisa_ssa_wb_arbiter

// File: tb/tb_lisa_ssa_wb_arbiter.sv
// tb/tb_lisa_ssa_wb_arbiter.sv - self-checking bench for lisa_ssa_wb_arbiter
module tb_lisa_ssa_wb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
`ifdef LISA_SSA_WRITE_ONCE_CHECK_EN
    localparam bit WO = 1'b1;
`else
    localparam bit WO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*8-1:0]  req_addr;
    logic [N*DW-1:0] req_data;
    logic            clear;
    logic            wen;
    logic [7:0]      waddr;
    logic [DW-1:0]   wdata;
    logic            busy;
    logic            err_double_write;
    logic [7:0]      err_addr;

    lisa_ssa_wb_arbiter #(
        .NUM_REQ  (N),
        .DATA_W   (DW),
        .NUM_REGS (256)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .clear            (clear),
        .wen              (wen),
        .waddr            (waddr),
        .wdata            (wdata),
        .busy             (busy),
        .err_double_write (err_double_write),
        .err_addr         (err_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_ptr;
    bit         m_wen;
    logic [7:0] m_waddr;
    logic [31:0] m_wdata;
    bit         m_err;
    logic [7:0] m_eaddr;
    bit         m_wr[256];

    // Values seen at the most recent mid-cycle sample
    logic [N-1:0] s_ready;
    logic         s_wen;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [31:0] d);
        req_addr[i*8 +: 8]  = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_err = 0; m_eaddr = 0;
        foreach (m_wr[j]) m_wr[j] = 1'b0;
    endtask

    // One clock: sample and compare mid-cycle, advance the model, then
    // return just after the rising edge so the caller can drive new inputs.
    task automatic step();
        int         g;
        bit         dup;
        logic [7:0] a;
        @(negedge clk);
        g = rst ? -1 : ref_grant(req_valid, m_ptr);
        s_ready = req_ready;
        s_wen   = wen;
        check_eq("ready", req_ready, (g < 0) ? 64'd0 : 64'(1 << g));
        check_eq("wen",   wen,   m_wen);
        check_eq("waddr", waddr, m_waddr);
        check_eq("wdata", wdata, m_wdata);
        check_eq("busy",  busy,  m_wen | (|req_valid));
        check_eq("err",   err_double_write, m_err);
        check_eq("err_addr", err_addr, m_eaddr);
        if (rst) begin
            model_reset();
        end else begin
            dup = 1'b0;
            a   = 8'h00;
            if (g >= 0) begin
                a   = req_addr[g*8 +: 8];
                dup = WO && m_wr[a] && !clear;
            end
            if (WO && clear) foreach (m_wr[j]) m_wr[j] = 1'b0;
            if (WO && g >= 0) m_wr[a] = 1'b1;
            if (g >= 0 && !dup) begin
                m_wen   = 1'b1;
                m_waddr = a;
                m_wdata = req_data[g*DW +: DW];
            end else begin
                m_wen = 1'b0;
            end
            if (dup) begin
                if (!m_err) m_eaddr = a;
                m_err = 1'b1;
            end
            if (g >= 0) m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; clear = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // Single write from requester 0
        set_req(0, 8'h05, 32'hDEADBEEF);
        req_valid = 4'b0001;
        step();
        check_eq("t1_ready", s_ready, 4'b0001);
        check_eq("t1_wen", wen, 1);
        check_eq("t1_waddr", waddr, 8'h05);
        check_eq("t1_wdata", wdata, 32'hDEADBEEF);
        req_valid = '0;
        step();
        check_eq("t1_wen_off", wen, 0);
        check_eq("t1_waddr_hold", waddr, 8'h05);

        // All four valid from ptr=0: strict rotation, one write per cycle
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 8'h40 + 8'(i), 32'hA000_0000 + i);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq("t2_grant", s_ready, 64'(1 << (k % N)));
            check_eq("t2_wen", wen, 1);
            check_eq("t2_waddr", waddr, 8'h40 + 8'(k % N));
        end

        // Wrap-around from ptr=3
        req_valid = 4'b0100;
        step();
        check_eq("t3_g2", s_ready, 4'b0100);
        req_valid = 4'b0001;
        step();
        check_eq("t3_wrap", s_ready, 4'b0001);
        req_valid = 4'b1010;
        step();
        check_eq("t3_g1", s_ready, 4'b0010);
        step();
        check_eq("t3_g3", s_ready, 4'b1000);

        // Reset right after a handshake
        req_valid = 4'b0001;
        step();
        rst = 1'b1;
        step();
        check_eq("t4_ready_in_rst", s_ready, 4'b0000);
        rst = 1'b0;
        req_valid = 4'b1111;
        step();
        check_eq("t4_wen_after_rst", s_wen, 0);
        check_eq("t4_ptr0", s_ready, 4'b0001);

        // Duplicate writes to one SSA ID
        do_reset();
        set_req(0, 8'h10, 32'h1111_0000);
        req_valid = 4'b0001;
        step();
        check_eq("t5_first_wen", wen, 1);
        set_req(2, 8'h10, 32'h2222_0000);
        req_valid = 4'b0100;
        step();
        check_eq("t5_dup_ready", s_ready, 4'b0100);
        check_eq("t5_dup_wen", wen, !WO);
        check_eq("t5_dup_err", err_double_write, WO);
        check_eq("t5_dup_eaddr", err_addr, WO ? 8'h10 : 8'h00);
        set_req(3, 8'h11, 32'h3333_0000);
        req_valid = 4'b1000;
        step();
        step();
        check_eq("t5_eaddr_kept", err_addr, WO ? 8'h10 : 8'h00);

        // clear between two writes to the same ID
        do_reset();
        set_req(0, 8'h20, 32'h2020_2020);
        req_valid = 4'b0001;
        step();
        check_eq("t6_wen1", wen, 1);
        req_valid = '0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        req_valid = 4'b0001;
        step();
        check_eq("t6_wen2", wen, 1);
        check_eq("t6_noerr", err_double_write, 0);

        // Randomized traffic against the model
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 39) == 0);
            clear = ($urandom_range(0, 19) == 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_req(i, 8'($urandom_range(0, 15)), $urandom);
            step();
        end
        rst = 1'b0; clear = 1'b0; req_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_lisa_ssa_wb_arbiter
